wb_evict_buffer: RTL and testbench

WB_EVICT_BUFFER -- requirements
Module: wb_evict_buffer

---
 rtl/wb_evict_buffer.sv | 180 ++++++++++++++++++
 tb/tb_wb_evict_buffer.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_evict_buffer.sv
// Write-back eviction buffer: holds dirty lines evicted by the dcache, writes each one
// out as an address phase followed by a burst of data beats, and frees the entry once
// the matching write response comes back. The buffer also answers hazard lookups for
// lines that are still queued or in flight.
module wb_evict_buffer #(
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned LineWidth = 128,
    parameter int unsigned BusWidth  = 64,
    parameter int unsigned Depth     = 2,
    parameter int unsigned IdWidth   = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 evict_valid_i,
    output logic                 evict_ready_o,
    input  logic [AddrWidth-1:0] evict_addr_i,
    input  logic [LineWidth-1:0] evict_data_i,
    output logic                 wr_req_valid_o,
    input  logic                 wr_req_ready_i,
    output logic [AddrWidth-1:0] wr_req_addr_o,
    output logic [IdWidth-1:0]   wr_req_id_o,
    output logic                 wr_data_valid_o,
    input  logic                 wr_data_ready_i,
    output logic [BusWidth-1:0]  wr_data_o,
    output logic                 wr_data_last_o,
    input  logic                 wr_rsp_valid_i,
    input  logic [IdWidth-1:0]   wr_rsp_id_i,
    input  logic [AddrWidth-1:0] lookup_addr_i,
    output logic                 lookup_hit_o,
    output logic                 empty_o
);

    localparam int unsigned Beats = LineWidth / BusWidth;
    localparam int unsigned PtrW  = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned BeatW = (Beats > 1) ? $clog2(Beats) : 1;
    localparam int unsigned OffW  = $clog2(LineWidth / 8);

    // Byte-offset bits inside a line; cleared on capture and ignored on lookup.
    localparam logic [AddrWidth-1:0] OffMask  = AddrWidth'((64'd1 << OffW) - 64'd1);
    localparam logic [AddrWidth-1:0] LineMask = ~OffMask;
    localparam logic [BeatW-1:0]     LastBeat = BeatW'(Beats - 1);

    typedef enum logic [1:0] {
        EntFree,
        EntQueued,
        EntWaitRsp
    } ent_state_e;

    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StData
    } issue_state_e;

    ent_state_e             ent_state_q [Depth];
    ent_state_e             ent_state_d [Depth];
    logic [AddrWidth-1:0]   ent_addr_q  [Depth];
    logic [LineWidth-1:0]   ent_data_q  [Depth];

    logic [PtrW-1:0]        alloc_ptr_q, alloc_ptr_d;
    logic [PtrW-1:0]        issue_ptr_q, issue_ptr_d;
    issue_state_e           fsm_q, fsm_d;
    logic [BeatW-1:0]       beat_q, beat_d;

    logic                   evict_fire;
    logic                   rsp_in_range;
    logic [PtrW-1:0]        rsp_idx;
    logic                   beat_is_last;
    logic [Beats-1:0][BusWidth-1:0] issue_beats;

    // Ready depends only on registered state so a same-cycle response never leaks into it.
    assign evict_ready_o = (ent_state_q[alloc_ptr_q] == EntFree);
    assign evict_fire    = evict_valid_i && evict_ready_o;

    // Depth is a power of two, so an ID is in range iff its bits above the index are zero.
    assign rsp_in_range  = ((wr_rsp_id_i >> PtrW) == '0);
    assign rsp_idx       = wr_rsp_id_i[PtrW-1:0];

    assign beat_is_last  = (beat_q == LastBeat);
    assign issue_beats   = ent_data_q[issue_ptr_q];

    // Drive the write channels from the issue FSM state and the entry under issue_ptr.
    always_comb begin
        wr_req_valid_o  = (fsm_q == StAddr);
        wr_req_addr_o   = ent_addr_q[issue_ptr_q];
        wr_req_id_o     = IdWidth'(issue_ptr_q);
        wr_data_valid_o = (fsm_q == StData);
        wr_data_o       = issue_beats[beat_q];
        wr_data_last_o  = (fsm_q == StData) && beat_is_last;
    end

    // Next-state for entry states, pointers, issue FSM and beat counter.
    always_comb begin
        ent_state_d = ent_state_q;
        alloc_ptr_d = alloc_ptr_q;
        issue_ptr_d = issue_ptr_q;
        fsm_d       = fsm_q;
        beat_d      = beat_q;

        if (evict_fire) begin
            ent_state_d[alloc_ptr_q] = EntQueued;
            alloc_ptr_d              = alloc_ptr_q + PtrW'(1);
        end

        unique case (fsm_q)
            StIdle: begin
                if (ent_state_q[issue_ptr_q] == EntQueued) begin
                    fsm_d = StAddr;
                end
            end
            StAddr: begin
                if (wr_req_ready_i) begin
                    fsm_d  = StData;
                    beat_d = '0;
                end
            end
            StData: begin
                if (wr_data_ready_i) begin
                    if (beat_is_last) begin
                        ent_state_d[issue_ptr_q] = EntWaitRsp;
                        issue_ptr_d              = issue_ptr_q + PtrW'(1);
                        fsm_d                    = StIdle;
                        beat_d                   = '0;
                    end else begin
                        beat_d = beat_q + BeatW'(1);
                    end
                end
            end
            default: fsm_d = StIdle;
        endcase

        // A response only frees an entry that is already waiting; anything else is dropped.
        // Allocation and last-beat transitions never target a WAIT_RSP entry, so no conflict.
        if (wr_rsp_valid_i && rsp_in_range && (ent_state_q[rsp_idx] == EntWaitRsp)) begin
            ent_state_d[rsp_idx] = EntFree;
        end
    end

    // Hazard lookup and empty flag over all live entries.
    always_comb begin
        lookup_hit_o = 1'b0;
        empty_o      = 1'b1;
        for (int i = 0; i < Depth; i++) begin
            if (ent_state_q[i] != EntFree) begin
                empty_o = 1'b0;
                if (((ent_addr_q[i] ^ lookup_addr_i) & LineMask) == '0) begin
                    lookup_hit_o = 1'b1;
                end
            end
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < Depth; i++) begin
                ent_state_q[i] <= EntFree;
            end
            alloc_ptr_q <= '0;
            issue_ptr_q <= '0;
            fsm_q       <= StIdle;
            beat_q      <= '0;
        end else begin
            ent_state_q <= ent_state_d;
            alloc_ptr_q <= alloc_ptr_d;
            issue_ptr_q <= issue_ptr_d;
            fsm_q       <= fsm_d;
            beat_q      <= beat_d;
        end
    end

    // Line payload capture; no reset needed since state gates every use.
    always_ff @(posedge clk_i) begin
        if (evict_fire) begin
            ent_addr_q[alloc_ptr_q] <= evict_addr_i & LineMask;
            ent_data_q[alloc_ptr_q] <= evict_data_i;
        end
    end

endmodule

// File: tb/tb_wb_evict_buffer.sv
// Bench for wb_evict_buffer: directed scenarios followed by a randomized run checked
// against a line-level model (a FIFO of accepted lines plus per-slot busy/awaiting flags).
module tb_wb_evict_buffer;

    localparam int DEPTH = 2;
    localparam int BEATS = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         evict_valid;
    logic         evict_ready;
    logic [63:0]  evict_addr;
    logic [127:0] evict_data;
    logic         wr_req_valid;
    logic         wr_req_ready;
    logic [63:0]  wr_req_addr;
    logic [3:0]   wr_req_id;
    logic         wr_data_valid;
    logic         wr_data_ready;
    logic [63:0]  wr_data;
    logic         wr_data_last;
    logic         wr_rsp_valid;
    logic [3:0]   wr_rsp_id;
    logic [63:0]  lookup_addr;
    logic         lookup_hit;
    logic         empty;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [63:0]  addr;
        logic [127:0] data;
        int           slot;
    } line_t;

    line_t       pend_q[$];
    bit          busy    [DEPTH];
    bit          waiting [DEPTH];
    logic [63:0] slot_line [DEPTH];
    int          n_acc;
    bit          in_data;
    int          beat;

    wb_evict_buffer #(
        .AddrWidth (64),
        .LineWidth (128),
        .BusWidth  (64),
        .Depth     (DEPTH),
        .IdWidth   (4)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .evict_valid_i   (evict_valid),
        .evict_ready_o   (evict_ready),
        .evict_addr_i    (evict_addr),
        .evict_data_i    (evict_data),
        .wr_req_valid_o  (wr_req_valid),
        .wr_req_ready_i  (wr_req_ready),
        .wr_req_addr_o   (wr_req_addr),
        .wr_req_id_o     (wr_req_id),
        .wr_data_valid_o (wr_data_valid),
        .wr_data_ready_i (wr_data_ready),
        .wr_data_o       (wr_data),
        .wr_data_last_o  (wr_data_last),
        .wr_rsp_valid_i  (wr_rsp_valid),
        .wr_rsp_id_i     (wr_rsp_id),
        .lookup_addr_i   (lookup_addr),
        .lookup_hit_o    (lookup_hit),
        .empty_o         (empty)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        evict_valid  = 1'b0;
        wr_rsp_valid = 1'b0;
        wr_rsp_id    = '0;
        lookup_addr  = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_dvalid(input string tag);
        for (int i = 0; i < 20 && wr_data_valid !== 1'b1; i++) tick();
        chk(tag, wr_data_valid, 1'b1);
    endtask

    function automatic logic [63:0] pool_addr();
        return 64'h8000_0000 + 64'($urandom_range(0, 255));
    endfunction

    // One randomized cycle: drive, check against the model, advance the model past the edge.
    task automatic rand_cycle(input bit drain);
        bit    exp_ready;
        bit    exp_hit;
        bit    exp_empty;
        int    rsp_free;
        line_t cur;

        evict_valid   = drain ? 1'b0 : ($urandom_range(0, 1) == 1);
        evict_addr    = pool_addr();
        evict_data    = {$urandom, $urandom, $urandom, $urandom};
        wr_req_ready  = drain || ($urandom_range(0, 3) != 0);
        wr_data_ready = drain || ($urandom_range(0, 3) != 0);
        if (drain) begin
            wr_rsp_valid = 1'b0;
            wr_rsp_id    = '0;
            for (int s = 0; s < DEPTH; s++) begin
                if (waiting[s]) begin
                    wr_rsp_valid = 1'b1;
                    wr_rsp_id    = 4'(s);
                end
            end
        end else begin
            wr_rsp_valid = ($urandom_range(0, 2) == 0);
            wr_rsp_id    = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15))
                                                       : 4'($urandom_range(0, DEPTH - 1));
        end
        lookup_addr = ($urandom_range(0, 1) == 1) ? pool_addr()
                    : (slot_line[$urandom_range(0, DEPTH - 1)] | 64'($urandom_range(0, 15)));
        #1;

        exp_ready = !busy[n_acc % DEPTH];
        exp_empty = 1'b1;
        exp_hit   = 1'b0;
        for (int s = 0; s < DEPTH; s++) begin
            if (busy[s]) begin
                exp_empty = 1'b0;
                if (slot_line[s][63:4] == lookup_addr[63:4]) exp_hit = 1'b1;
            end
        end
        chk("rnd_evict_ready", evict_ready, exp_ready);
        chk("rnd_empty", empty, exp_empty);
        chk("rnd_lookup_hit", lookup_hit, exp_hit);
        chk("rnd_req_and_data", wr_req_valid & wr_data_valid, 1'b0);
        chk("rnd_last_idle", wr_data_last & !wr_data_valid, 1'b0);
        if (wr_req_valid) begin
            chk("rnd_req_phase", {in_data, pend_q.size() == 0}, 2'b00);
            if (pend_q.size() > 0) begin
                chk("rnd_req_addr", wr_req_addr, pend_q[0].addr);
                chk("rnd_req_id", wr_req_id, 4'(pend_q[0].slot));
            end
        end
        if (wr_data_valid) begin
            chk("rnd_data_phase", in_data, 1'b1);
            if (in_data) begin
                chk("rnd_data", wr_data, 64'(pend_q[0].data >> (beat * 64)));
                chk("rnd_last", wr_data_last, beat == BEATS - 1);
            end
        end

        // Responses act on lines already awaiting one before this edge.
        rsp_free = -1;
        if (wr_rsp_valid && int'(wr_rsp_id) < DEPTH && waiting[int'(wr_rsp_id)]) begin
            rsp_free = int'(wr_rsp_id);
        end
        if (wr_data_valid && wr_data_ready && in_data) begin
            beat++;
            if (beat == BEATS) begin
                waiting[pend_q[0].slot] = 1'b1;
                void'(pend_q.pop_front());
                in_data = 1'b0;
                beat    = 0;
            end
        end else if (wr_req_valid && wr_req_ready && !in_data && pend_q.size() > 0) begin
            in_data = 1'b1;
            beat    = 0;
        end
        if (evict_valid && exp_ready) begin
            cur.addr = evict_addr & ~64'hF;
            cur.data = evict_data;
            cur.slot = n_acc % DEPTH;
            pend_q.push_back(cur);
            busy[cur.slot]      = 1'b1;
            slot_line[cur.slot] = cur.addr;
            n_acc++;
        end
        if (rsp_free >= 0) begin
            busy[rsp_free]    = 1'b0;
            waiting[rsp_free] = 1'b0;
        end
        tick();
    endtask

    initial begin
        bit found;
        int nbeats;

        evict_valid   = 1'b0;
        evict_addr    = '0;
        evict_data    = '0;
        wr_req_ready  = 1'b1;
        wr_data_ready = 1'b1;
        wr_rsp_valid  = 1'b0;
        wr_rsp_id     = '0;
        lookup_addr   = '0;
        do_reset();

        // Reset state.
        chk("rst_evict_ready", evict_ready, 1'b1);
        chk("rst_req_valid", wr_req_valid, 1'b0);
        chk("rst_data_valid", wr_data_valid, 1'b0);
        chk("rst_data_last", wr_data_last, 1'b0);
        chk("rst_lookup_hit", lookup_hit, 1'b0);
        chk("rst_empty", empty, 1'b1);

        // Single line, all readies high: request at N+2, beats A then B, response empties.
        evict_valid = 1'b1;
        evict_addr  = 64'h8000_0040;
        evict_data  = {64'hB, 64'hA};
        tick();
        evict_valid = 1'b0;
        chk("one_n1_req_valid", wr_req_valid, 1'b0);
        tick();
        chk("one_n2_req_valid", wr_req_valid, 1'b1);
        chk("one_n2_req_addr", wr_req_addr, 64'h8000_0040);
        chk("one_n2_req_id", wr_req_id, 4'd0);
        chk("one_n2_data_valid", wr_data_valid, 1'b0);
        tick();
        chk("one_beat0_valid", wr_data_valid, 1'b1);
        chk("one_beat0_data", wr_data, 64'hA);
        chk("one_beat0_last", wr_data_last, 1'b0);
        tick();
        chk("one_beat1_valid", wr_data_valid, 1'b1);
        chk("one_beat1_data", wr_data, 64'hB);
        chk("one_beat1_last", wr_data_last, 1'b1);
        tick();
        chk("one_after_valid", wr_data_valid | wr_req_valid, 1'b0);
        chk("one_wait_empty", empty, 1'b0);
        wr_rsp_valid = 1'b1;
        wr_rsp_id    = 4'd0;
        tick();
        wr_rsp_valid = 1'b0;
        chk("one_rsp_empty", empty, 1'b1);

        // Fill both entries, free them out of order.
        do_reset();
        evict_valid = 1'b1;
        evict_addr  = 64'h8000_0100;
        evict_data  = {64'h11, 64'h10};
        tick();
        chk("fill_ready_e1", evict_ready, 1'b1);
        evict_addr = 64'h8000_0200;
        evict_data = {64'h21, 64'h20};
        tick();
        evict_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("fill_full_ready", evict_ready, 1'b0);
        wr_rsp_valid = 1'b1;
        wr_rsp_id    = 4'd1;
        tick();
        wr_rsp_valid = 1'b0;
        chk("fill_rsp1_ready", evict_ready, 1'b0);
        chk("fill_rsp1_empty", empty, 1'b0);
        lookup_addr = 64'h8000_0200;
        #1;
        chk("fill_rsp1_line1_hit", lookup_hit, 1'b0);
        lookup_addr = 64'h8000_0100;
        #1;
        chk("fill_rsp1_line0_hit", lookup_hit, 1'b1);
        wr_rsp_valid = 1'b1;
        wr_rsp_id    = 4'd0;
        #1;
        chk("fill_rsp0_same_cycle", evict_ready, 1'b0);
        tick();
        wr_rsp_valid = 1'b0;
        chk("fill_rsp0_ready", evict_ready, 1'b1);
        chk("fill_rsp0_empty", empty, 1'b1);

        // Data stall during beat 0.
        do_reset();
        wr_data_ready = 1'b0;
        evict_valid   = 1'b1;
        evict_addr    = 64'h8000_0300;
        evict_data    = {64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        tick();
        evict_valid = 1'b0;
        wait_dvalid("stall_wait_beat0");
        for (int i = 0; i < 3; i++) begin
            chk("stall_valid", wr_data_valid, 1'b1);
            chk("stall_data", wr_data, 64'h1111_1111_1111_1111);
            chk("stall_last", wr_data_last, 1'b0);
            tick();
        end
        wr_data_ready = 1'b1;
        nbeats = 0;
        for (int i = 0; i < 6; i++) begin
            if (wr_data_valid) begin
                chk("stall_beat_data", wr_data,
                    (nbeats == 0) ? 64'h1111_1111_1111_1111 : 64'h2222_2222_2222_2222);
                chk("stall_beat_last", wr_data_last, nbeats == 1);
                nbeats++;
            end
            tick();
        end
        chk("stall_beat_count", nbeats, 2);

        // Hazard lookup against a queued line.
        do_reset();
        wr_req_ready = 1'b0;
        evict_valid  = 1'b1;
        evict_addr   = 64'h8000_1000;
        evict_data   = {64'h5, 64'h4};
        lookup_addr  = 64'h8000_1008;
        #1;
        chk("lk_same_cycle", lookup_hit, 1'b0);
        tick();
        evict_valid = 1'b0;
        chk("lk_hit", lookup_hit, 1'b1);
        lookup_addr = 64'h8000_1010;
        #1;
        chk("lk_miss_next_line", lookup_hit, 1'b0);
        wr_req_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        wr_rsp_valid = 1'b1;
        wr_rsp_id    = 4'd0;
        tick();
        wr_rsp_valid = 1'b0;
        lookup_addr  = 64'h8000_1008;
        #1;
        chk("lk_after_rsp", lookup_hit, 1'b0);

        // Reset during beat 0.
        do_reset();
        evict_valid = 1'b1;
        evict_addr  = 64'h8000_0400;
        evict_data  = {64'h7, 64'h6};
        tick();
        evict_valid = 1'b0;
        wait_dvalid("mid_rst_wait_beat0");
        chk("mid_rst_beat0_last", wr_data_last, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valids", {wr_req_valid, wr_data_valid, wr_data_last}, 3'b000);
        chk("mid_rst_empty", empty, 1'b1);
        chk("mid_rst_ready", evict_ready, 1'b1);

        // Spurious responses to queued entries are ignored.
        do_reset();
        wr_req_ready = 1'b0;
        evict_valid  = 1'b1;
        evict_addr   = 64'h8000_0500;
        evict_data   = {64'h9, 64'h8};
        tick();
        evict_addr = 64'h8000_0600;
        evict_data = {64'hD, 64'hC};
        tick();
        evict_valid  = 1'b0;
        wr_rsp_valid = 1'b1;
        wr_rsp_id    = 4'd1;
        tick();
        wr_rsp_id = 4'd5;
        tick();
        wr_rsp_valid = 1'b0;
        chk("spur_empty", empty, 1'b0);
        chk("spur_ready", evict_ready, 1'b0);
        lookup_addr = 64'h8000_0600;
        #1;
        chk("spur_line1_hit", lookup_hit, 1'b1);
        wr_req_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (wr_req_valid && wr_req_id == 4'd1) found = 1'b1;
            else tick();
        end
        chk("spur_e1_issued", found, 1'b1);
        chk("spur_e1_addr", wr_req_addr, 64'h8000_0600);

        // Randomized traffic against the line-level model, then drain.
        do_reset();
        pend_q.delete();
        for (int s = 0; s < DEPTH; s++) begin
            busy[s]      = 1'b0;
            waiting[s]   = 1'b0;
            slot_line[s] = 64'h8000_0000;
        end
        n_acc   = 0;
        in_data = 1'b0;
        beat    = 0;
        for (int i = 0; i < 3000; i++) rand_cycle(1'b0);
        for (int i = 0; i < 100; i++) rand_cycle(1'b1);
        chk("drain_empty", empty, 1'b1);
        chk("drain_model_empty", pend_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
